puf_challenge_sequencer: RTL
============================

// Module: puf_challenge_sequencer
// PURPOSE
//  Sequences one RO-PUF enrolment/authentication run. Seeds the 4-bit challenge LFSR and steps it N_CHAL times.
//  For each challenge: clears the RO counters, enables the ring oscillators for a fixed window, then captures one
//  comparator bit. Assembles the bits into an N_CHAL-bit response word.
//  Sits between the host/UART command logic and the lfsr + RO-pair/counter/comparator datapath.
// PARAMETERS
//  N_CHAL       4     challenges per run = response width (2..16)
//  EVAL_CYCLES  1024  clk cycles ro_en is held high per challenge (>=2); timer width $clog2(EVAL_CYCLES)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-high
//  start       in   1       request a run; sampled only in IDLE
//  abort       in   1       cancel the run in progress
//  seed        in   4       LFSR seed, latched when start is accepted
//  lfsr_seed   out  4       seed value driven to the lfsr seed input
//  lfsr_load   out  1       registered one-cycle pulse; loads lfsr_seed into the LFSR
//  lfsr_en     out  1       registered one-cycle pulse; advances the LFSR one step
//  lfsr_q      in   4       current LFSR state (challenge)
//  chal        out  4       registered challenge applied to the RO mux select
//  cnt_clr     out  1       one-cycle clear of both RO counters
//  ro_en       out  1       enables the selected ring oscillators and counters
//  cmp_bit     in   1       comparator result (count A > count B); valid whenever ro_en=0
//  busy        out  1       high in every state except IDLE
//  resp        out  N_CHAL  response word; updated only in DONE
//  resp_valid  out  1       one-cycle pulse when resp is updated
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (lfsr_seed, chal, resp = 0; all strobes low); index and timer = 0.
//  All outputs are registered (no combinational paths from inputs to outputs). lfsr_load is glitch-free.
//  FSM states:
//  - IDLE: start=1 -> latch seed; if seed==0, substitute 4'h1 (avoids LFSR lock-up); -> SEED.
//  - SEED: lfsr_load=1 for this cycle only; idx=0; -> SETTLE.
//  - SETTLE: chal<=lfsr_q; cnt_clr=1; timer<=EVAL_CYCLES-1; -> EVAL.
//  - EVAL: ro_en=1. Timer decrements each cycle. When timer==0 -> CAPTURE.
//    ro_en is high for exactly EVAL_CYCLES cycles.
//  - CAPTURE: ro_en=0; shift cmp_bit into the shift register: sr<={sr[N_CHAL-2:0],cmp_bit}.
//    First challenge's bit ends up in resp[N_CHAL-1].
//    If idx==N_CHAL-1 -> DONE; else idx++ and -> STEP.
//  - STEP: lfsr_en=1 for this cycle only; -> SETTLE. The LFSR updates at the end of STEP.
//    SETTLE therefore samples the new state.
//  - DONE: resp<=sr; resp_valid=1 for this cycle only; -> IDLE.
//  Latency: resp_valid is high in the cycle that begins N_CHAL*(EVAL_CYCLES+3)+1 edges after the edge sampling start.
//  Handshake and boundary conditions:
//  - start while busy is ignored; no queueing.
//  - start in the DONE cycle is ignored.
//  - A new start is accepted in IDLE the cycle after resp_valid.
//  - abort has priority over all transitions in any non-IDLE state:
//    -> IDLE next edge; ro_en, lfsr_en and cnt_clr drop next edge; resp and resp_valid unchanged/not pulsed.
//    abort in IDLE is ignored. If start and abort are both high in IDLE, start is accepted.
//  - Asynchronous reset mid-run: immediate return to IDLE with all outputs cleared; resp is lost.
//  - idx and timer never wrap: idx saturates at N_CHAL-1; timer is reloaded only in SETTLE.
//  - lfsr_seed holds the latched (substituted) seed until the next accepted start.
// TESTING  (bench params N_CHAL=4, EVAL_CYCLES=8; pair with the real lfsr; latency 45 edges)
//  - Reset released, idle: all outputs 0, busy=0 for 20 cycles, no strobes.
//  - Basic run:
//    - Stimulus: seed=4'h1, start 1 cycle, cmp_bit = 1,0,1,1 in the successive CAPTURE cycles.
//    - Response: chal sequence 1,2,5,A; resp_valid at edge +45; resp=4'b1011.
//    - Check ro_en: 4 pulses, each exactly 8 cycles wide; cnt_clr precedes each pulse.
//  - Zero seed: seed=4'h0 -> lfsr_seed=4'h1, chal sequence 1,2,5,A, run completes normally.
//  - Ignored start: start re-pulsed during EVAL -> exactly one resp_valid.
//    start in the cycle after resp_valid -> second run accepted.
//  - Abort in EVAL of the 3rd challenge -> IDLE next edge, ro_en=0, no resp_valid, resp keeps its prior value.
//    Then a new run with seed=4'hA gives chal sequence A,4,8,1.
//  - Async reset asserted mid-EVAL (between clock edges) -> outputs 0 immediately, busy=0, no resp_valid after release.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Sequences one RO-PUF run: seeds and steps the challenge LFSR, times each ring-oscillator
// evaluation window and shifts the captured comparator bits into an N_CHAL-bit response.
module puf_challenge_sequencer #(
  parameter int N_CHAL      = 4,
  parameter int EVAL_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        seed,
  output logic [3:0]        lfsr_seed,
  output logic              lfsr_load,
  output logic              lfsr_en,
  input  logic [3:0]        lfsr_q,
  output logic [3:0]        chal,
  output logic              cnt_clr,
  output logic              ro_en,
  input  logic              cmp_bit,
  output logic              busy,
  output logic [N_CHAL-1:0] resp,
  output logic              resp_valid
);

  localparam int TIMER_W = $clog2(EVAL_CYCLES);
  localparam int IDX_W   = $clog2(N_CHAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_SETTLE,
    S_EVAL,
    S_CAPTURE,
    S_STEP,
    S_DONE
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   idx;
  logic [N_CHAL-1:0]  sr;

  // Every strobe is a flop set on the edge that enters its state, so each one is high for
  // exactly the duration of that state and nothing combinational reaches an output pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      idx        <= '0;
      sr         <= '0;
      lfsr_seed  <= '0;
      lfsr_load  <= 1'b0;
      lfsr_en    <= 1'b0;
      chal       <= '0;
      cnt_clr    <= 1'b0;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state
      // and the one-cycle strobes below default low before a state re-asserts them.
      lfsr_load  <= 1'b0;
      lfsr_en    <= 1'b0;
      cnt_clr    <= 1'b0;
      resp_valid <= 1'b0;

      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        ro_en <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              // An all-zero seed would lock the LFSR.
              lfsr_seed <= (seed == 4'h0) ? 4'h1 : seed;
              lfsr_load <= 1'b1;
              busy      <= 1'b1;
              state     <= S_SEED;
            end
          end
          S_SEED: begin
            idx     <= '0;
            cnt_clr <= 1'b1;
            state   <= S_SETTLE;
          end
          S_SETTLE: begin
            chal  <= lfsr_q;
            timer <= TIMER_W'(EVAL_CYCLES - 1);
            ro_en <= 1'b1;
            state <= S_EVAL;
          end
          S_EVAL: begin
            if (timer == '0) begin
              ro_en <= 1'b0;
              state <= S_CAPTURE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_CAPTURE: begin
            sr <= {sr[N_CHAL-2:0], cmp_bit};
            if (idx == IDX_W'(N_CHAL - 1)) begin
              state <= S_DONE;
            end else begin
              idx     <= idx + 1'b1;
              lfsr_en <= 1'b1;
              state   <= S_STEP;
            end
          end
          S_STEP: begin
            cnt_clr <= 1'b1;
            state   <= S_SETTLE;
          end
          S_DONE: begin
            resp       <= sr;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          default: begin
            ro_en <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
